multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore state-machine control unit for the multicycle MIPS-subset datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the ALU operand selects (including the 2-bit ALU-B source select), ALU function, PC update, memory strobes and register-file write controls. It sits beside the datapath, reads opcode/funct from the instruction register, and reads the ALU zero flag and the memory ready flag.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the access this cycle
- pc_en  out  1  PC register load enable (includes branch condition)
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register: 0 rt, 1 rd
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- alu_ctrl  out  3  001 ADD, 010 SUB, 011 AND, 100 OR, 111 SLT, 000 none
- trap  out  1  illegal instruction detected; sticky until reset

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
- Outputs are a pure decode of state plus alu_zero, opcode, funct and mem_ready. Every output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_source=00.
  - ir_write and pc_en equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 → R_EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x08 → I_EXEC
  - 0x04 or 0x05 → BRANCH
  - 0x02 → JUMP
  - any other opcode → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next is MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: mem_read=1, i_or_d=1. Hold while mem_ready=0, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold while mem_ready=0, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl is decoded from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT
  - any other funct: alu_ctrl=000 and next state TRAP instead of R_WB
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctrl held from R_EXEC. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, ADD. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01.
  - pc_en = alu_zero for opcode 0x04, ~alu_zero for 0x05.
  - Next FETCH.
- JUMP: pc_source=10, pc_en=1. Next FETCH.
- TRAP: trap=1, all other outputs 0. Stays in TRAP until reset.

## Timing
- Reset: reset_n=0 at a rising edge forces state RESET on that edge, from any state. Outputs are therefore all 0 in the following cycle.
- Reset mid-instruction: the in-flight instruction is abandoned and no write strobe is issued after the reset edge.
- Cycles per instruction, counting from the FETCH cycle with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each cycle of mem_ready=0 spent in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_read/mem_write remain asserted and stable for the whole wait.
- pc_en and ir_write never assert in FETCH unless mem_ready=1 in the same cycle.
- reg_write and mem_write are never both 1 in the same cycle.
- alu_src_b never changes while in a mem_ready wait.

## Structure
- Package multicycle_ctrl_pkg holds:
  - the state enum (4 bits)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J
  - funct constants
  - ALU-B select encodings: SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2
  - alu_ctrl encodings
- One sub-module, alu_funct_decode: combinational, funct → alu_ctrl plus an illegal flag. Used by R_EXEC and R_WB.
- The state register is the only sequential element; trap is derived from state.

## Test plan
- Reset: hold reset_n=0 for 2 cycles, then release. Required: all outputs 0 during RESET; the first FETCH has mem_read=1, alu_src_b=01, alu_ctrl=001.
- lw (opcode 0x23), mem_ready always 1. Required:
  - 5 cycles FETCH→DECODE→MEM_ADDR→MEM_RD→MEM_WB
  - alu_src_b sequence 01,11,10,00,00
  - reg_write=1 and mem_to_reg=1 only in cycle 5
- sw with mem_ready=0 for 3 cycles in MEM_WR. Required: mem_write=1 and i_or_d=1 for 4 cycles, then FETCH; reg_write never 1.
- beq with alu_zero=1 → pc_en=1, pc_source=01 in BRANCH. bne with alu_zero=1 → pc_en=0. Both return to FETCH after 3 cycles.
- R-type, funct 0x22 → alu_ctrl=010 in R_EXEC and R_WB, reg_dst=1 in R_WB. Funct 0x3F → TRAP with trap=1 held for 10 cycles, cleared only by reset_n=0.
- Opcode 0x3F → TRAP after DECODE. Separately, reset_n=0 asserted during MEM_RD → next cycle is RESET and no reg_write occurs.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [SRCB_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [ALUC_W-1:0] ALU_NONE = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_AND  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_OR   = 3'b100;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b111;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  // Full control word driven toward the datapath each cycle.
  typedef struct packed {
    logic               pc_en;
    logic [PCSRC_W-1:0] pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [SRCB_W-1:0]  alu_src_b;
    logic [ALUC_W-1:0]  alu_ctrl;
    logic               trap;
  } ctrl_out_t;

  // beq takes the branch on zero, bne on non-zero.
  function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic zero);
    logic taken;
    taken = 1'b0;
    if (op == OP_BEQ) taken = zero;
    else if (op == OP_BNE) taken = ~zero;
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in, control strobes out.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               alu_zero;
  logic               mem_ready;

  logic               pc_en;
  logic [PCSRC_W-1:0] pc_source;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [SRCB_W-1:0]  alu_src_b;
  logic [ALUC_W-1:0]  alu_ctrl;
  logic               trap;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, trap
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, trap
  );
endinterface

// File: rtl/multicycle_ctrl_alu_funct_decode.sv
// R-type funct field to ALU operation, flagging unsupported functs.
module alu_funct_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alu_ctrl,
  output logic               illegal
);

  always_comb begin
    alu_ctrl = ALU_NONE;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing fetch/decode/execute/memory/write-back for the multicycle datapath.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  multicycle_ctrl_if.master   bus
);

  state_e            state_q, state_d;
  ctrl_out_t         out_c;
  logic [ALUC_W-1:0] r_alu_ctrl;
  logic              r_illegal;

  alu_funct_decode u_funct_decode (
    .funct    (bus.funct),
    .alu_ctrl (r_alu_ctrl),
    .illegal  (r_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  // Next state and the control word for the current state.
  always_comb begin
    state_d = state_q;
    out_c   = '0;
    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        out_c.mem_read  = 1'b1;
        out_c.i_or_d    = 1'b0;
        out_c.alu_src_a = 1'b0;
        out_c.alu_src_b = SRCB_FOUR;
        out_c.alu_ctrl  = ALU_ADD;
        out_c.pc_source = PCSRC_ALU;
        out_c.ir_write  = bus.mem_ready;
        out_c.pc_en     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        out_c.alu_src_a = 1'b0;
        out_c.alu_src_b = SRCB_IMM_SH2;
        out_c.alu_ctrl  = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_ADDI:        state_d = S_I_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = SRCB_IMM;
        out_c.alu_ctrl  = ALU_ADD;
        if (bus.opcode == OP_LW)      state_d = S_MEM_RD;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WR;
        else                          state_d = S_TRAP;
      end

      S_MEM_RD: begin
        out_c.mem_read = 1'b1;
        out_c.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        out_c.reg_write  = 1'b1;
        out_c.mem_to_reg = 1'b1;
        out_c.reg_dst    = 1'b0;
        state_d          = S_FETCH;
      end

      S_MEM_WR: begin
        out_c.mem_write = 1'b1;
        out_c.i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_R_EXEC: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = SRCB_REG;
        out_c.alu_ctrl  = r_alu_ctrl;
        state_d         = r_illegal ? S_TRAP : S_R_WB;
      end

      S_R_WB: begin
        // funct is still held in IR, so the decode re-derives the same operation.
        out_c.reg_write  = 1'b1;
        out_c.reg_dst    = 1'b1;
        out_c.mem_to_reg = 1'b0;
        out_c.alu_ctrl   = r_alu_ctrl;
        state_d          = S_FETCH;
      end

      S_I_EXEC: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = SRCB_IMM;
        out_c.alu_ctrl  = ALU_ADD;
        state_d         = S_I_WB;
      end

      S_I_WB: begin
        out_c.reg_write  = 1'b1;
        out_c.reg_dst    = 1'b0;
        out_c.mem_to_reg = 1'b0;
        state_d          = S_FETCH;
      end

      S_BRANCH: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = SRCB_REG;
        out_c.alu_ctrl  = ALU_SUB;
        out_c.pc_source = PCSRC_ALUOUT;
        out_c.pc_en     = branch_taken(bus.opcode, bus.alu_zero);
        state_d         = S_FETCH;
      end

      S_JUMP: begin
        out_c.pc_source = PCSRC_JUMP;
        out_c.pc_en     = 1'b1;
        state_d         = S_FETCH;
      end

      S_TRAP: begin
        out_c.trap = 1'b1;
        state_d    = S_TRAP;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign bus.pc_en      = out_c.pc_en;
  assign bus.pc_source  = out_c.pc_source;
  assign bus.i_or_d     = out_c.i_or_d;
  assign bus.mem_read   = out_c.mem_read;
  assign bus.mem_write  = out_c.mem_write;
  assign bus.ir_write   = out_c.ir_write;
  assign bus.reg_dst    = out_c.reg_dst;
  assign bus.mem_to_reg = out_c.mem_to_reg;
  assign bus.reg_write  = out_c.reg_write;
  assign bus.alu_src_a  = out_c.alu_src_a;
  assign bus.alu_src_b  = out_c.alu_src_b;
  assign bus.alu_ctrl   = out_c.alu_ctrl;
  assign bus.trap       = out_c.trap;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl with hand-computed control words.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       trap;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    exp_t       exp;
    string      tag;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[$];

  exp_t E_ZERO, E_FWAIT, E_FRDY, E_DEC, E_MADDR, E_MRD, E_MWB, E_MWR;
  exp_t E_IEX, E_IWB, E_JMP, E_TRAP, E_BR_T, E_BR_N;
  exp_t E_REX_SUB, E_RWB_SUB, E_REX_OR, E_RWB_OR, E_REX_SLT, E_RWB_SLT, E_REX_BAD;

  multicycle_ctrl_if bus();

  multicycle_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic pc_en, input logic [1:0] pcs, input logic iord,
                              input logic mrd, input logic mwr, input logic irw,
                              input logic rdst, input logic m2r, input logic rw,
                              input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                              input logic trap);
    exp_t e;
    e.pc_en = pc_en; e.pc_source = pcs; e.i_or_d = iord; e.mem_read = mrd;
    e.mem_write = mwr; e.ir_write = irw; e.reg_dst = rdst; e.mem_to_reg = m2r;
    e.reg_write = rw; e.alu_src_a = sa; e.alu_src_b = sb; e.alu_ctrl = alu; e.trap = trap;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.pc_en = bus.pc_en; a.pc_source = bus.pc_source; a.i_or_d = bus.i_or_d;
    a.mem_read = bus.mem_read; a.mem_write = bus.mem_write; a.ir_write = bus.ir_write;
    a.reg_dst = bus.reg_dst; a.mem_to_reg = bus.mem_to_reg; a.reg_write = bus.reg_write;
    a.alu_src_a = bus.alu_src_a; a.alu_src_b = bus.alu_src_b; a.alu_ctrl = bus.alu_ctrl;
    a.trap = bus.trap;
    return a;
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input exp_t e, input string tag);
    vec_t v;
    v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", tag, act, req);
    end
  endtask

  initial begin
    int n;
    int wb_cycle;
    n_cmp = 0;
    n_bad = 0;

    //          pc_en pcs   iord mrd mwr irw rdst m2r rw sa  sb     alu     trap
    E_ZERO    = '0;
    E_FWAIT   = mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b001, 0);
    E_FRDY    = mk(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b001, 0);
    E_DEC     = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b001, 0);
    E_MADDR   = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 0);
    E_MRD     = mk(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_MWB     = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0);
    E_MWR     = mk(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_IEX     = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001, 0);
    E_IWB     = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0);
    E_JMP     = mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    E_TRAP    = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);
    E_BR_T    = mk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    E_BR_N    = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    E_REX_SUB = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    E_RWB_SUB = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0);
    E_REX_OR  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b100, 0);
    E_RWB_OR  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b100, 0);
    E_REX_SLT = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b111, 0);
    E_RWB_SLT = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b111, 0);
    E_REX_BAD = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 0);

    // Each row is one clock cycle; the FSM state carries over row to row.
    add(0, 6'h00, 6'h00, 0, 1, E_ZERO,  "reset_held");
    add(1, 6'h00, 6'h00, 0, 1, E_ZERO,  "reset_release");
    add(1, 6'h23, 6'h00, 0, 0, E_FWAIT, "fetch_wait");
    add(1, 6'h23, 6'h00, 0, 1, E_FRDY,  "lw_fetch");
    add(1, 6'h23, 6'h00, 0, 1, E_DEC,   "lw_decode");
    add(1, 6'h23, 6'h00, 0, 1, E_MADDR, "lw_memaddr");
    add(1, 6'h23, 6'h00, 0, 1, E_MRD,   "lw_memrd");
    add(1, 6'h23, 6'h00, 0, 1, E_MWB,   "lw_memwb");
    add(1, 6'h2B, 6'h00, 0, 1, E_FRDY,  "sw_fetch");
    add(1, 6'h2B, 6'h00, 0, 1, E_DEC,   "sw_decode");
    add(1, 6'h2B, 6'h00, 0, 1, E_MADDR, "sw_memaddr");
    add(1, 6'h2B, 6'h00, 0, 0, E_MWR,   "sw_wait1");
    add(1, 6'h2B, 6'h00, 0, 0, E_MWR,   "sw_wait2");
    add(1, 6'h2B, 6'h00, 0, 0, E_MWR,   "sw_wait3");
    add(1, 6'h2B, 6'h00, 0, 1, E_MWR,   "sw_done");
    add(1, 6'h04, 6'h00, 1, 1, E_FRDY,  "beq_fetch");
    add(1, 6'h04, 6'h00, 1, 1, E_DEC,   "beq_decode");
    add(1, 6'h04, 6'h00, 1, 1, E_BR_T,  "beq_z1");
    add(1, 6'h05, 6'h00, 1, 1, E_FRDY,  "bne_fetch");
    add(1, 6'h05, 6'h00, 1, 1, E_DEC,   "bne_decode");
    add(1, 6'h05, 6'h00, 1, 1, E_BR_N,  "bne_z1");
    add(1, 6'h05, 6'h00, 0, 1, E_FRDY,  "bne2_fetch");
    add(1, 6'h05, 6'h00, 0, 1, E_DEC,   "bne2_decode");
    add(1, 6'h05, 6'h00, 0, 1, E_BR_T,  "bne_z0");
    add(1, 6'h04, 6'h00, 0, 1, E_FRDY,  "beq2_fetch");
    add(1, 6'h04, 6'h00, 0, 1, E_DEC,   "beq2_decode");
    add(1, 6'h04, 6'h00, 0, 1, E_BR_N,  "beq_z0");
    add(1, 6'h08, 6'h00, 0, 1, E_FRDY,  "addi_fetch");
    add(1, 6'h08, 6'h00, 0, 1, E_DEC,   "addi_decode");
    add(1, 6'h08, 6'h00, 0, 1, E_IEX,   "addi_exec");
    add(1, 6'h08, 6'h00, 0, 1, E_IWB,   "addi_wb");
    add(1, 6'h02, 6'h00, 0, 1, E_FRDY,  "j_fetch");
    add(1, 6'h02, 6'h00, 0, 1, E_DEC,   "j_decode");
    add(1, 6'h02, 6'h00, 0, 1, E_JMP,   "j_jump");
    add(1, 6'h00, 6'h22, 0, 1, E_FRDY,  "sub_fetch");
    add(1, 6'h00, 6'h22, 0, 1, E_DEC,   "sub_decode");
    add(1, 6'h00, 6'h22, 0, 1, E_REX_SUB, "sub_exec");
    add(1, 6'h00, 6'h22, 0, 1, E_RWB_SUB, "sub_wb");
    add(1, 6'h00, 6'h25, 0, 1, E_FRDY,  "or_fetch");
    add(1, 6'h00, 6'h25, 0, 1, E_DEC,   "or_decode");
    add(1, 6'h00, 6'h25, 0, 1, E_REX_OR, "or_exec");
    add(1, 6'h00, 6'h25, 0, 1, E_RWB_OR, "or_wb");
    add(1, 6'h00, 6'h2A, 0, 1, E_FRDY,  "slt_fetch");
    add(1, 6'h00, 6'h2A, 0, 1, E_DEC,   "slt_decode");
    add(1, 6'h00, 6'h2A, 0, 1, E_REX_SLT, "slt_exec");
    add(1, 6'h00, 6'h2A, 0, 1, E_RWB_SLT, "slt_wb");
    add(1, 6'h00, 6'h3F, 0, 1, E_FRDY,  "badfn_fetch");
    add(1, 6'h00, 6'h3F, 0, 1, E_DEC,   "badfn_decode");
    add(1, 6'h00, 6'h3F, 0, 1, E_REX_BAD, "badfn_exec");
    for (int k = 0; k < 10; k++)
      add(1, 6'(k), 6'h20, 1'(k), 1'(k >> 1), E_TRAP, "trap_hold");
    add(0, 6'h00, 6'h00, 0, 1, E_TRAP,  "trap_reset_edge");
    add(1, 6'h3F, 6'h00, 0, 1, E_ZERO,  "trap_cleared");
    add(1, 6'h3F, 6'h00, 0, 1, E_FRDY,  "badop_fetch");
    add(1, 6'h3F, 6'h00, 0, 1, E_DEC,   "badop_decode");
    add(1, 6'h3F, 6'h00, 0, 1, E_TRAP,  "badop_trap");
    add(0, 6'h3F, 6'h00, 0, 1, E_TRAP,  "badop_reset_edge");
    add(1, 6'h23, 6'h00, 0, 1, E_ZERO,  "badop_cleared");
    add(1, 6'h23, 6'h00, 0, 1, E_FRDY,  "rstmid_fetch");
    add(1, 6'h23, 6'h00, 0, 1, E_DEC,   "rstmid_decode");
    add(1, 6'h23, 6'h00, 0, 1, E_MADDR, "rstmid_memaddr");
    add(0, 6'h23, 6'h00, 0, 0, E_MRD,   "rstmid_memrd");
    add(1, 6'h23, 6'h00, 0, 1, E_ZERO,  "rstmid_no_wb");

    reset_n       = 1'b0;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_n       = vecs[i].rst_n;
      bus.opcode    = vecs[i].op;
      bus.funct     = vecs[i].fn;
      bus.alu_zero  = vecs[i].z;
      bus.mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("%s[%0d]", vecs[i].tag, i), 32'(sample()), 32'(vecs[i].exp));
    end

    // lw with two FETCH waits and two MEM_RD waits: write-back lands on cycle 5+2+2.
    wb_cycle = 0;
    for (n = 1; n <= 20 && wb_cycle == 0; n++) begin
      @(negedge clk);
      reset_n       = 1'b1;
      bus.opcode    = 6'h23;
      bus.funct     = 6'h00;
      bus.alu_zero  = 1'b0;
      bus.mem_ready = !(n == 1 || n == 2 || n == 6 || n == 7);
      #1;
      if (n >= 6 && n <= 8)
        check($sformatf("lw_wait_rd[%0d]", n),
              32'({bus.mem_read, bus.i_or_d, bus.alu_src_b, bus.reg_write}), 32'(5'b11000));
      if (n == 1 || n == 2)
        check($sformatf("lw_wait_fetch[%0d]", n),
              32'({bus.mem_read, bus.pc_en, bus.ir_write, bus.alu_src_b}), 32'(5'b10001));
      if (bus.reg_write) begin
        wb_cycle = n;
        check("lw_wait_m2r", 32'(bus.mem_to_reg), 32'd1);
      end
    end
    check("lw_wait_wb_cycle", 32'(wb_cycle), 32'd9);

    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("lw_wait_back_fetch", 32'(sample()), 32'(E_FRDY));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
